// File: rtl/pseq_pkg.sv
// Shared definitions for the program sequencer: default sizes, next-address
// source encoding and the page-aligned jump-target helper.
package pseq_pkg;

  localparam int PSEQ_PC_WIDTH    = 8;
  localparam int PSEQ_JMP_WIDTH   = 4;
  localparam int PSEQ_STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    NA_ZERO,
    NA_HOLD,
    NA_RET,
    NA_JUMP,
    NA_INC
  } next_addr_e;

  // The jump field selects a page; the low PC bits of the target are zero.
  function automatic logic [31:0] page_target(input logic [31:0] page, input int shift);
    return page << shift;
  endfunction

endpackage

// File: rtl/pseq_return_stack.sv
// LIFO return-address stack (pointer plus entry array). Only built when
// PSEQ_CALL_STACK_EN is defined; the default build leaves this file empty.
`ifdef PSEQ_CALL_STACK_EN
module pseq_return_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LW-1:0]    level_q, level_d;
  logic [AW-1:0]    wr_idx, rd_idx;

  assign full   = (level_q == LW'(DEPTH));
  assign empty  = (level_q == '0);
  assign level  = level_q;
  assign wr_idx = AW'(level_q);
  assign rd_idx = AW'(level_q - LW'(1));
  assign dout   = mem_q[rd_idx];

  always_comb begin
    // NOTE: default first so every path assigns level_d and no latch is inferred.
    level_d = level_q;
    if (clear)               level_d = '0;
    else if (pop && !empty)  level_d = level_q - LW'(1);
    else if (push && !full)  level_d = level_q + LW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so all flops sample together.
    if (reset) level_q <= '0;
    else       level_q <= level_d;
  end

  // NOTE: entry storage is not reset; entries above level are never read.
  always_ff @(posedge clk) begin
    if (push && !full && !clear) mem_q[wr_idx] <= din;
  end

endmodule
`endif

// File: rtl/stack_program_sequencer.sv
// Program sequencer: priority next-address mux, pc register and stack flags.
// Define PSEQ_CALL_STACK_EN to build the call/ret return-address stack.
module stack_program_sequencer
  import pseq_pkg::*;
#(
  parameter int PC_WIDTH    = PSEQ_PC_WIDTH,
  parameter int JMP_WIDTH   = PSEQ_JMP_WIDTH,
  parameter int STACK_DEPTH = PSEQ_STACK_DEPTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             sync_reset,
  input  logic                             hold,
  input  logic                             jmp,
  input  logic                             jmp_nz,
  input  logic                             dont_jmp,
  input  logic                             call,
  input  logic                             ret,
  input  logic [JMP_WIDTH-1:0]             jmp_addr,
  output logic [PC_WIDTH-1:0]              pm_addr,
  output logic [PC_WIDTH-1:0]              pc,
  output logic [PC_WIDTH-1:0]              from_ps,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level,
  output logic                             stack_ovf,
  output logic                             stack_unf
);

  localparam int LW = $clog2(STACK_DEPTH + 1);

  logic [PC_WIDTH-1:0] pc_q, pc_d, inc, target;
  next_addr_e          sel;

  assign inc     = pc_q + PC_WIDTH'(1);
  assign target  = PC_WIDTH'(page_target(32'(jmp_addr), PC_WIDTH - JMP_WIDTH));
  assign pc      = pc_q;
  assign from_ps = inc;
  assign pc_d    = pm_addr;

`ifdef PSEQ_CALL_STACK_EN
  logic                push, pop, full, empty;
  logic                ovf_q, ovf_d, unf_q, unf_d;
  logic [PC_WIDTH-1:0] stack_dout;

  pseq_return_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .clear (sync_reset),
    .push  (push),
    .pop   (pop),
    .din   (inc),
    .dout  (stack_dout),
    .level (stack_level),
    .full  (full),
    .empty (empty)
  );

  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;
`else
  logic unused_ret;
  assign unused_ret  = ret;
  assign stack_level = LW'(0);
  assign stack_ovf   = 1'b0;
  assign stack_unf   = 1'b0;
`endif

  always_comb begin
    sel = NA_INC;
`ifdef PSEQ_CALL_STACK_EN
    push  = 1'b0;
    pop   = 1'b0;
    ovf_d = ovf_q;
    unf_d = unf_q;
`endif
    if (sync_reset) sel = NA_ZERO;
    else if (hold)  sel = NA_HOLD;
`ifdef PSEQ_CALL_STACK_EN
    // An empty-stack ret falls through to the sequential address.
    else if (ret) begin
      if (empty) unf_d = 1'b1;
      else begin
        sel = NA_RET;
        pop = 1'b1;
      end
    end
    else if (call) begin
      sel = NA_JUMP;
      if (full) ovf_d = 1'b1;
      else      push  = 1'b1;
    end
`else
    else if (call) sel = NA_JUMP;
`endif
    else if (jmp || (jmp_nz && !dont_jmp)) sel = NA_JUMP;

`ifdef PSEQ_CALL_STACK_EN
    if (sync_reset) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
`endif

    case (sel)
      NA_ZERO: pm_addr = '0;
      NA_HOLD: pm_addr = pc_q;
`ifdef PSEQ_CALL_STACK_EN
      NA_RET:  pm_addr = stack_dout;
`endif
      NA_JUMP: pm_addr = target;
      default: pm_addr = inc;
    endcase
    if (reset) pm_addr = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

`ifdef PSEQ_CALL_STACK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
`endif

endmodule

// File: doc/stack_program_sequencer.md
# stack_program_sequencer

Parametrised next-generation program sequencer for the microprocessor. It generates the program-memory fetch address and holds the program counter (address of the instruction currently in the instruction register). It adds three things to the fixed 8-bit sequencer: configurable address and jump widths, a fetch stall, and a hardware return-address stack for `call`/`ret`. It sits between the instruction decoder (control strobes, jump field) and the program memory (address).

## Interface
Parameters:
- `PC_WIDTH`, default 8: program-counter and fetch-address width; must be greater than `JMP_WIDTH`.
- `JMP_WIDTH`, default 4: width of the jump field. Target = `{jmp_addr, (PC_WIDTH-JMP_WIDTH)'b0}` (page-aligned).
- `STACK_DEPTH`, default 4: number of return-address entries; power of two, at least 2.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sync_reset`  in  1  synchronous restart to address 0.
- `hold`  in  1  stall; refetch the current address.
- `jmp`  in  1  unconditional jump.
- `jmp_nz`  in  1  conditional jump.
- `dont_jmp`  in  1  condition false; suppresses `jmp_nz`.
- `call`  in  1  push the return address, then jump.
- `ret`  in  1  pop the stack; the popped value becomes the next address.
- `jmp_addr`  in  JMP_WIDTH  jump/call page field.
- `pm_addr`  out  PC_WIDTH  next fetch address (combinational).
- `pc`  out  PC_WIDTH  registered program counter.
- `from_ps`  out  PC_WIDTH  link value, `pc + 1`, for storing into the register file.
- `stack_level`  out  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- `stack_ovf`  out  1  sticky: a `call` occurred while the stack was full.
- `stack_unf`  out  1  sticky: a `ret` occurred while the stack was empty.

## Operation
- `pm_addr` is selected by strict priority:
  1. `reset`: 0.
  2. `sync_reset`: 0.
  3. `hold`: `pc`.
  4. `ret`: top of stack, or `pc+1` if the stack is empty.
  5. `call`: jump target.
  6. `jmp`: jump target.
  7. `jmp_nz & ~dont_jmp`: jump target.
  8. Otherwise: `pc+1`.
- `pc+1` wraps modulo 2^PC_WIDTH; 2^PC_WIDTH−1 → 0.
- `pc` loads `pm_addr` on every clock edge, including during `hold`, when it reloads its own value.
- A `call` that wins priority pushes `pc+1` and increments `stack_level`.
- If the stack is full, the call still jumps, the push is discarded, `stack_level` stays at STACK_DEPTH, and `stack_ovf` sets.
- A `ret` that wins priority pops and decrements `stack_level`.
- If the stack is empty, a `ret` falls through to `pc+1`, `stack_level` stays 0, and `stack_unf` sets.
- Simultaneous `call` and `ret`: `ret` wins; there is no push and the call target is ignored.
- `hold` blocks all stack changes and control-flow strobes.
- `sync_reset` clears `pc`, `stack_level` and both flags, and has priority over every strobe.
- The stack is LIFO: a pointer plus an entry array. Entry contents are don't-care when not valid.

## Timing
- Reset values (asynchronous, immediate): `pc`=0, `pm_addr`=0 (held 0 while `reset` is high), `from_ps`=1, `stack_level`=0, `stack_ovf`=0, `stack_unf`=0.
- `pm_addr` has zero-cycle latency from the strobes and `pc`.
- `pc` lags `pm_addr` by exactly one cycle.
- A taken jump, call or ret costs no bubble; the target is fetched in the same cycle the strobe is high.
- The stack pointer and entries update on the same edge that loads `pc`. A `ret` in the cycle after a `call` returns that call's `pc+1`.
- Flags stay set until `reset` or `sync_reset`.
- `reset` asserted mid-call or mid-stall aborts immediately; there is no partial push.

## Configuration
- `PSEQ_CALL_STACK_EN` defined: stack, `call`/`ret`, `stack_level` and the flags behave as described above.
- `PSEQ_CALL_STACK_EN` undefined:
  - No stack storage is built.
  - `call` behaves as `jmp`.
  - `ret` is ignored, so the next address is `pc+1` unless another strobe applies.
  - `stack_level`, `stack_ovf` and `stack_unf` are tied to 0.
  - The port list is unchanged.

## Structure
- Shared package `pseq_pkg` holds:
  - default widths/depth constants;
  - an enum for the next-address source (`NA_ZERO`, `NA_HOLD`, `NA_RET`, `NA_JUMP`, `NA_INC`);
  - a function forming the page-aligned target.
- One sub-module, `pseq_return_stack`, contains `push`, `pop`, `din`, `dout`, `level`, `full`, `empty`, parametrised by width and depth.
- The top contains the priority mux, the `pc` register and the flag logic.

## Test plan
- Reset, then 3 idle cycles: `pm_addr` = 0 during reset, then 1, 2, 3; `pc` follows one cycle later; `from_ps` = `pc+1`.
- At `pc`=0x2A, `jmp_nz`=1 with `dont_jmp`=1: `pm_addr`=0x2B. With `dont_jmp`=0 and `jmp_addr`=0x3: `pm_addr`=0x30.
- At `pc`=0x05, `call` page 0x4: `pm_addr`=0x40, `stack_level`=1. Two cycles later `ret`: `pm_addr`=0x06, `stack_level`=0.
- Five nested calls with depth 4: fifth call jumps, `stack_ovf`=1, `stack_level`=4. `ret` on an empty stack at `pc`=0x10: `pm_addr`=0x11, `stack_unf`=1. `sync_reset` clears both flags.
- `hold`=1 for 3 cycles with `jmp` and `call` pulsed: `pm_addr`=`pc` throughout, no stack change. `pc`=0xFF idle gives `pm_addr`=0x00 (wrap).
- Build without `PSEQ_CALL_STACK_EN`: `call` page 0x7 gives `pm_addr`=0x70; `ret` at `pc`=0x71 gives 0x72; `stack_level`, `stack_ovf` and `stack_unf` stay 0.
